// File: rtl/risc16_pkg.sv
// Shared definitions for the risc16 front end: fetch FSM states, opcode values,
// instruction field positions and fetch buffer sizing.
package risc16_pkg;

    localparam int WORD_W     = 16;
    localparam int FIFO_DEPTH = 2;
    localparam int ENTRY_W    = 2 * WORD_W;
    localparam int PTR_W      = 1;
    localparam int CNT_W      = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_ADDI = 3'd1;
    localparam logic [2:0] OP_NAND = 3'd2;
    localparam logic [2:0] OP_LUI  = 3'd3;
    localparam logic [2:0] OP_SW   = 3'd4;
    localparam logic [2:0] OP_LW   = 3'd5;
    localparam logic [2:0] OP_BEQ  = 3'd6;
    localparam logic [2:0] OP_JALR = 3'd7;

    localparam int OPCODE_LSB = 13;
    localparam int REG_A_LSB  = 10;
    localparam int REG_B_LSB  = 7;
    localparam int REG_C_LSB  = 0;
    localparam int IMM7_W     = 7;
    localparam int IMM10_W    = 10;

    function automatic logic [2:0] reg_field(input logic [WORD_W-1:0] word, input int lsb);
        return word[lsb +: 3];
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry fetch buffer holding {instruction, pc}; flush empties it and wins
// over any push or pop in the same cycle.
module fetch_fifo
    import risc16_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  logic [ENTRY_W-1:0] push_data,
    input  logic               pop,
    input  logic               flush,
    output logic [ENTRY_W-1:0] head_data,
    output logic [CNT_W-1:0]   count
);

    logic [ENTRY_W-1:0] mem_reg [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_reg;
    logic [PTR_W-1:0]   rd_ptr_reg;
    logic [CNT_W-1:0]   count_reg;
    logic               do_push;
    logic               do_pop;

    assign do_pop  = pop && (count_reg != '0);
    assign do_push = push && ((count_reg != CNT_W'(FIFO_DEPTH)) || do_pop);

    genvar gi;
    generate
        for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    mem_reg[gi] <= '0;
                end else if (!flush && do_push && (wr_ptr_reg == PTR_W'(gi))) begin
                    mem_reg[gi] <= push_data;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            count_reg <= count_reg + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Present zeros when empty so stale entries never leak to decode.
    assign head_data = (count_reg != '0) ? mem_reg[rd_ptr_reg] : '0;
    assign count     = count_reg;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: single-outstanding memory requests feeding a two-entry
// buffer, with flush handling that drains an in-flight request before refetching.
module instr_fetch
    import risc16_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WORD_W-1:0] pc_addr,
    output logic              pc_advance,
    input  logic              flush,
    output logic              imem_req,
    output logic [WORD_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [WORD_W-1:0] imem_rdata,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [WORD_W-1:0] instr_out,
    output logic [WORD_W-1:0] instr_pc,
    output logic [2:0]        opcode,
    output logic [2:0]        reg_a,
    output logic [2:0]        reg_b,
    output logic [2:0]        reg_c,
    output logic [6:0]        imm7,
    output logic [9:0]        imm10
);

    fetch_state_e      state_reg, state_next;
    logic              req_reg, req_next;
    logic [WORD_W-1:0] addr_reg, addr_next;
    logic              fifo_push;
    logic              fifo_pop;
    logic [CNT_W-1:0]  fifo_count;
    logic [ENTRY_W-1:0] fifo_head;
    logic              ack_valid;
    logic              can_issue;

    // An ack only counts while our own request is pending; strays after reset are ignored.
    assign ack_valid = req_reg && imem_ack;
    assign can_issue = !req_reg && !flush && (fifo_count < CNT_W'(FIFO_DEPTH));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            req_reg   <= 1'b0;
            addr_reg  <= '0;
        end else begin
            state_reg <= state_next;
            req_reg   <= req_next;
            addr_reg  <= addr_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        req_next   = req_reg;
        addr_next  = addr_reg;
        fifo_push  = 1'b0;
        pc_advance = 1'b0;
        case (state_reg)
            IDLE: begin
                state_next = FETCH;
            end
            FETCH: begin
                if (ack_valid) begin
                    req_next = 1'b0;
                    if (!flush) begin
                        fifo_push  = 1'b1;
                        pc_advance = 1'b1;
                    end
                end else if (req_reg && flush) begin
                    state_next = DRAIN;
                end else if (can_issue) begin
                    req_next  = 1'b1;
                    addr_next = pc_addr;
                end
            end
            DRAIN: begin
                if (ack_valid) begin
                    req_next   = 1'b0;
                    state_next = FETCH;
                end
            end
            default: begin
                state_next = IDLE;
                req_next   = 1'b0;
            end
        endcase
    end

    assign fifo_pop = instr_valid && instr_ready;

    fetch_fifo u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data ({imem_rdata, addr_reg}),
        .pop       (fifo_pop),
        .flush     (flush),
        .head_data (fifo_head),
        .count     (fifo_count)
    );

    assign imem_req    = req_reg;
    assign imem_addr   = addr_reg;
    assign instr_valid = (fifo_count != '0);
    assign instr_out   = fifo_head[ENTRY_W-1:WORD_W];
    assign instr_pc    = fifo_head[WORD_W-1:0];

    assign opcode = instr_out[OPCODE_LSB +: 3];
    assign reg_a  = reg_field(instr_out, REG_A_LSB);
    assign reg_b  = reg_field(instr_out, REG_B_LSB);
    assign reg_c  = reg_field(instr_out, REG_C_LSB);
    assign imm7   = instr_out[IMM7_W-1:0];
    assign imm10  = instr_out[IMM10_W-1:0];

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: reset, single fetch, buffer full stall, flush
// variants, streaming order and reset abandoning an outstanding request.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] pc_addr;
    logic        pc_advance;
    logic        flush;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr_out;
    logic [15:0] instr_pc;
    logic [2:0]  opcode, reg_a, reg_b, reg_c;
    logic [6:0]  imm7;
    logic [9:0]  imm10;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    instr_fetch dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pc_addr     (pc_addr),
        .pc_advance  (pc_advance),
        .flush       (flush),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_out   (instr_out),
        .instr_pc    (instr_pc),
        .opcode      (opcode),
        .reg_a       (reg_a),
        .reg_b       (reg_b),
        .reg_c       (reg_c),
        .imm7        (imm7),
        .imm10       (imm10)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] q_data [$];
        logic [15:0] q_pc [$];
        int sent;
        int got;

        rst_n = 1'b0; pc_addr = 16'h0000; flush = 1'b0;
        imem_ack = 1'b0; imem_rdata = 16'h0000; instr_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", imem_req, 0);
        chk("rst_addr", imem_addr, 0);
        chk("rst_valid", instr_valid, 0);
        chk("rst_out", instr_out, 0);
        chk("rst_pc", instr_pc, 0);
        chk("rst_adv", pc_advance, 0);

        // Basic fetch of 0x2481 from address 0
        rst_n = 1'b1;
        tick();
        chk("idle_no_req", imem_req, 0);
        tick();
        chk("req1", imem_req, 1);
        chk("req1_addr", imem_addr, 16'h0000);
        imem_ack = 1'b1; imem_rdata = 16'h2481;
        #1;
        chk("adv1", pc_advance, 1);
        tick();
        imem_ack = 1'b0; pc_addr = 16'h0001;
        #1;
        chk("v1_valid", instr_valid, 1);
        chk("v1_out", instr_out, 16'h2481);
        chk("v1_pc", instr_pc, 16'h0000);
        chk("v1_opcode", opcode, 3'd1);
        chk("v1_reg_a", reg_a, 3'd1);
        chk("v1_reg_b", reg_b, 3'd1);
        chk("v1_reg_c", reg_c, 3'd1);
        chk("v1_imm7", imm7, 7'h01);
        chk("v1_imm10", imm10, 10'h081);
        chk("v1_req_drop", imem_req, 0);
        chk("v1_adv_clr", pc_advance, 0);

        // Fill the buffer with decode stalled
        tick();
        chk("req2", imem_req, 1);
        chk("req2_addr", imem_addr, 16'h0001);
        imem_ack = 1'b1; imem_rdata = 16'h1111;
        #1;
        chk("adv2", pc_advance, 1);
        tick();
        imem_ack = 1'b0; pc_addr = 16'h0002;
        #1;
        chk("full_req0", imem_req, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("full_req", imem_req, 0);
            chk("full_adv", pc_advance, 0);
            chk("full_head", instr_out, 16'h2481);
        end
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0; pc_addr = 16'h0010;
        #1;
        chk("pop_head", instr_out, 16'h1111);
        chk("pop_head_pc", instr_pc, 16'h0001);

        // Flush with a request outstanding: drain it, then refetch
        tick();
        chk("req3_addr", imem_addr, 16'h0010);
        chk("req3", imem_req, 1);
        flush = 1'b1;
        #1;
        chk("flush_adv", pc_advance, 0);
        tick();
        flush = 1'b0; pc_addr = 16'h0020;
        #1;
        chk("drain_valid", instr_valid, 0);
        chk("drain_req", imem_req, 1);
        chk("drain_addr", imem_addr, 16'h0010);
        tick();
        tick();
        chk("drain_req_hold", imem_req, 1);
        imem_ack = 1'b1; imem_rdata = 16'hFFFF;
        #1;
        chk("drain_ack_adv", pc_advance, 0);
        tick();
        imem_ack = 1'b0;
        #1;
        chk("drained_valid", instr_valid, 0);
        chk("drained_req", imem_req, 0);
        tick();
        chk("refetch_req", imem_req, 1);
        chk("refetch_addr", imem_addr, 16'h0020);

        // Flush coincident with ack and pop, one entry buffered
        imem_ack = 1'b1; imem_rdata = 16'hA5A5;
        #1;
        chk("adv4", pc_advance, 1);
        tick();
        imem_ack = 1'b0; pc_addr = 16'h0021;
        #1;
        chk("v4_out", instr_out, 16'hA5A5);
        chk("v4_pc", instr_pc, 16'h0020);
        tick();
        chk("req5_addr", imem_addr, 16'h0021);
        imem_ack = 1'b1; imem_rdata = 16'h1234; flush = 1'b1; instr_ready = 1'b1;
        #1;
        chk("flush_ack_adv", pc_advance, 0);
        tick();
        imem_ack = 1'b0; flush = 1'b0; instr_ready = 1'b0; pc_addr = 16'h0040;
        #1;
        chk("flush_ack_valid", instr_valid, 0);
        chk("flush_ack_req", imem_req, 0);
        tick();
        chk("req6_addr", imem_addr, 16'h0040);

        // Streaming 0x0100..0x0103 with decode back-pressure
        sent = 0;
        got  = 0;
        for (int k = 0; k < 60; k++) begin
            instr_ready = ((k % 5) >= 2);
            imem_ack    = imem_req && (sent < 4);
            imem_rdata  = 16'h0100 + 16'(sent);
            #1;
            if (pc_advance) begin
                q_data.push_back(imem_rdata);
                q_pc.push_back(pc_addr);
                sent++;
            end
            if (instr_valid && instr_ready) begin
                chk("stream_nonempty", 32'(q_data.size() != 0), 1);
                if (q_data.size() != 0) begin
                    chk("stream_data", instr_out, q_data.pop_front());
                    chk("stream_pc", instr_pc, q_pc.pop_front());
                    got++;
                end
            end
            tick();
            pc_addr = 16'h0040 + 16'(sent);
        end
        imem_ack = 1'b0; instr_ready = 1'b0;
        chk("stream_sent", sent, 4);
        chk("stream_got", got, 4);
        #1;
        chk("stream_pending_req", imem_req, 1);
        chk("stream_pending_addr", imem_addr, 16'h0044);

        // Reset with request outstanding, stray ack afterwards
        rst_n = 1'b0;
        #1;
        chk("rst2_req", imem_req, 0);
        chk("rst2_addr", imem_addr, 0);
        chk("rst2_valid", instr_valid, 0);
        chk("rst2_adv", pc_advance, 0);
        tick();
        rst_n = 1'b1; imem_ack = 1'b1; imem_rdata = 16'hDEAD;
        #1;
        chk("stray_adv_idle", pc_advance, 0);
        tick();
        chk("stray_adv_fetch", pc_advance, 0);
        chk("stray_req", imem_req, 0);
        tick();
        imem_ack = 1'b0;
        #1;
        chk("stray_valid", instr_valid, 0);
        chk("post_rst_req", imem_req, 1);
        chk("post_rst_addr", imem_addr, 16'h0044);
        imem_ack = 1'b1; imem_rdata = 16'hBEEF;
        #1;
        chk("post_rst_adv", pc_advance, 1);
        tick();
        imem_ack = 1'b0;
        #1;
        chk("post_rst_valid", instr_valid, 1);
        chk("post_rst_out", instr_out, 16'hBEEF);
        chk("post_rst_pc", instr_pc, 16'h0044);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
